// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS.
// Holds register map, waveform modes and midscale helper.
package dds_pkg;

  localparam logic [2:0] ADDR_FTW  = 3'd0;
  localparam logic [2:0] ADDR_OFS  = 3'd1;
  localparam logic [2:0] ADDR_MODE = 3'd2;
  localparam logic [2:0] ADDR_EN   = 3'd3;
  localparam logic [2:0] ADDR_STEP = 3'd4;

  typedef enum logic [1:0] {
    SAW      = 2'd0,
    SQUARE   = 2'd1,
    TRIANGLE = 2'd2,
    MUTE     = 2'd3
  } mode_e;

  function automatic logic [15:0] midscale(input int w);
    logic [15:0] m;
    m = '0;
    m[w-1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: phase accumulator plus waveform shaper.
// Output is registered, one cycle behind the accumulator.
module dds_channel
  import dds_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] ftw,
  input  logic [ACC_W-1:0] ofs,
  input  mode_e            mode,
  output logic [OUT_W-1:0] out
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p;
  logic [OUT_W:0]   q;
  logic [OUT_W-1:0] wave;

  // accumulate while enabled, park at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (en) acc <= acc + ftw;
    else acc <= '0;
  end

  // phase to sample shaping
  always_comb begin
    p = acc + ofs;
    q = (OUT_W+1)'(p >> (ACC_W-OUT_W-1));
    wave = OUT_W'(midscale(OUT_W));
    unique case (mode)
      SAW:      wave = q[OUT_W:1];
      SQUARE:   wave = {OUT_W{q[OUT_W]}};
      TRIANGLE: wave = q[OUT_W] ? ~q[OUT_W-1:0]
                                :  q[OUT_W-1:0];
      MUTE:     wave = OUT_W'(midscale(OUT_W));
      default:  wave = OUT_W'(midscale(OUT_W));
    endcase
  end

  // output register, midscale when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= OUT_W'(midscale(OUT_W));
    else if (!en) out <= OUT_W'(midscale(OUT_W));
    else out <= wave;
  end

endmodule

// File: rtl/dds_multi.sv
// Multi-channel DDS: shadow/active register file, commit, channels.
// Optional DDS_SWEEP_EN adds a per-channel linear frequency sweep.
module dds_multi
  import dds_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [$clog2(NCH>1 ? NCH : 2)-1:0] wr_ch,
  input  logic [2:0]                         wr_addr,
  input  logic [ACC_W-1:0]                   wr_data,
  input  logic                               set,
  output logic                               wr_err,
  output logic [NCH*OUT_W-1:0]               out
);

  localparam int CHW = $clog2(NCH>1 ? NCH : 2);

  logic commit_q;
  logic err_q;
  logic commit;
  logic wr_ok;
  logic ch_ok;
  logic addr_ok;
  logic hit;

  logic [ACC_W-1:0] sh_ftw [NCH];
  logic [ACC_W-1:0] sh_ofs [NCH];
  mode_e            sh_mode [NCH];
  logic [NCH-1:0]   sh_en;
  logic [ACC_W-1:0] ac_ftw [NCH];
  logic [ACC_W-1:0] ac_ofs [NCH];
  mode_e            ac_mode [NCH];
  logic [NCH-1:0]   ac_en;
`ifdef DDS_SWEEP_EN
  logic [ACC_W-1:0] sh_step [NCH];
  logic [ACC_W-1:0] ac_step [NCH];
`endif

  assign wr_ready = ~commit_q;
  assign wr_err   = err_q;
  assign commit   = set & ~commit_q;
  assign wr_ok    = wr_valid & ~commit_q;
  assign ch_ok    = 32'(wr_ch) < NCH;
`ifdef DDS_SWEEP_EN
  assign addr_ok  = wr_addr <= ADDR_STEP;
`else
  assign addr_ok  = wr_addr <= ADDR_EN;
`endif
  assign hit      = wr_ok & ch_ok & addr_ok;

  // commit cycle marker and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      commit_q <= commit;
      err_q    <= wr_ok & ~(ch_ok & addr_ok);
    end
  end

  // shadow register writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        sh_ftw[c]  <= '0;
        sh_ofs[c]  <= '0;
        sh_mode[c] <= SAW;
        sh_en[c]   <= 1'b0;
`ifdef DDS_SWEEP_EN
        sh_step[c] <= '0;
`endif
      end
    end else if (hit) begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ch == CHW'(c)) begin
          unique case (wr_addr)
            ADDR_FTW:  sh_ftw[c]  <= wr_data;
            ADDR_OFS:  sh_ofs[c]  <= wr_data;
            ADDR_MODE: sh_mode[c] <= mode_e'(wr_data[1:0]);
            ADDR_EN:   sh_en[c]   <= wr_data[0];
`ifdef DDS_SWEEP_EN
            ADDR_STEP: sh_step[c] <= wr_data;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // atomic commit to actives, sweep between commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        ac_ftw[c]  <= '0;
        ac_ofs[c]  <= '0;
        ac_mode[c] <= SAW;
        ac_en[c]   <= 1'b0;
`ifdef DDS_SWEEP_EN
        ac_step[c] <= '0;
`endif
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (commit) begin
          ac_ftw[c]  <= sh_ftw[c];
          ac_ofs[c]  <= sh_ofs[c];
          ac_mode[c] <= sh_mode[c];
          ac_en[c]   <= sh_en[c];
`ifdef DDS_SWEEP_EN
          ac_step[c] <= sh_step[c];
`endif
        end
`ifdef DDS_SWEEP_EN
        else if (ac_en[c]) begin
          ac_ftw[c] <= ac_ftw[c] + ac_step[c];
        end
`endif
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dds_channel #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (ac_en[c]),
      .ftw  (ac_ftw[c]),
      .ofs  (ac_ofs[c]),
      .mode (ac_mode[c]),
      .out  (out[c*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_dds_multi.sv
// Directed bench for dds_multi (2-channel default plus a 3-channel copy).
// Define DDS_SWEEP_EN to exercise the sweep build.
module tb_dds_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [0:0]  wr_ch = '0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        set = 1'b0;
  logic        wr_err;
  logic [15:0] out;

  logic        d3_valid = 1'b0;
  logic        d3_ready;
  logic [1:0]  d3_ch = '0;
  logic        d3_err;
  logic [23:0] d3_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dds_multi u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_ch   (wr_ch),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .set     (set),
    .wr_err  (wr_err),
    .out     (out)
  );

  dds_multi #(.NCH(3)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(d3_valid),
    .wr_ready(d3_ready),
    .wr_ch   (d3_ch),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .set     (1'b0),
    .wr_err  (d3_err),
    .out     (d3_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [0:0] ch,
                    input logic [2:0] a,
                    input logic [31:0] d);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_set;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] saw_e [5];
    logic [7:0] tri_e [5];
    saw_e = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    tri_e = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h00};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 32'h8080);
    chk("rst_rdy", 32'(wr_ready), 32'd1);
    chk("rst_err", 32'(wr_err), 32'd0);
    chk("rst_out3", 32'(d3_out), 32'h808080);
    rst_n = 1'b1;
    @(negedge clk);

    // ch0 saw at quarter rate
    wr(0, 3'd0, 32'h4000_0000);
    wr(0, 3'd2, 32'd0);
    wr(0, 3'd3, 32'd1);
    chk("saw_noset", 32'(out[7:0]), 32'h80);
    do_set;
    chk("commit_rdy", 32'(wr_ready), 32'd0);
    chk("saw_pre", 32'(out[7:0]), 32'h80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("saw", 32'(out[7:0]), 32'(saw_e[i]));
      chk("saw_ch1", 32'(out[15:8]), 32'h80);
    end
    chk("rdy_after", 32'(wr_ready), 32'd1);

    // triangle, restarted from zero phase
    wr(0, 3'd3, 32'd0);
    wr(0, 3'd2, 32'd2);
    do_set;
    @(negedge clk);
    wr(0, 3'd3, 32'd1);
    do_set;
    chk("tri_pre", 32'(out[7:0]), 32'h80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("tri", 32'(out[7:0]), 32'(tri_e[i]));
    end

    // shadow writes invisible until set
    wr(1, 3'd0, 32'h8000_0000);
    chk("ch1_hold", 32'(out[15:8]), 32'h80);
    wr(1, 3'd2, 32'd1);
    wr(1, 3'd3, 32'd1);
    wr(0, 3'd2, 32'd1);
    chk("ch1_hold2", 32'(out[15:8]), 32'h80);
    do_set;
    chk("c_rdy0", 32'(wr_ready), 32'd0);
    chk("c_ch0_old", 32'(out[7:0]), 32'h80);
    chk("c_ch1_old", 32'(out[15:8]), 32'h80);
    @(negedge clk);
    chk("c_rdy1", 32'(wr_ready), 32'd1);
    chk("c_ch0_new", 32'(out[7:0]), 32'hFF);
    chk("c_ch1_new", 32'(out[15:8]), 32'h00);
    @(negedge clk);
    chk("sq_ch0_a", 32'(out[7:0]), 32'hFF);
    chk("sq_ch1_a", 32'(out[15:8]), 32'hFF);
    @(negedge clk);
    chk("sq_ch0_b", 32'(out[7:0]), 32'h00);
    chk("sq_ch1_b", 32'(out[15:8]), 32'h00);

    // write and set on one edge: commit sees old shadow
    wr_valid = 1'b1;
    wr_ch    = 1'b1;
    wr_addr  = 3'd3;
    wr_data  = 32'd0;
    set      = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    set      = 1'b0;
    @(negedge clk);
    chk("ws_run", 32'(out[15:8] != 8'h80), 32'd1);
    do_set;
    @(negedge clk);
    chk("ws_off", 32'(out[15:8]), 32'h80);

    // write errors
    wr(0, 3'd6, 32'hFFFF_FFFF);
    chk("err_a6", 32'(wr_err), 32'd1);
    @(negedge clk);
    chk("err_a6_end", 32'(wr_err), 32'd0);
    wr(0, 3'd1, 32'd0);
    chk("err_a1", 32'(wr_err), 32'd0);
`ifdef DDS_SWEEP_EN
    wr(0, 3'd4, 32'd0);
    chk("err_a4", 32'(wr_err), 32'd0);
`else
    wr(0, 3'd4, 32'd0);
    chk("err_a4", 32'(wr_err), 32'd1);
`endif
    wr_addr  = 3'd0;
    d3_ch    = 2'd3;
    d3_valid = 1'b1;
    @(negedge clk);
    d3_valid = 1'b0;
    chk("err_ch3", 32'(d3_err), 32'd1);
    d3_ch    = 2'd2;
    d3_valid = 1'b1;
    @(negedge clk);
    d3_valid = 1'b0;
    chk("err_ch2", 32'(d3_err), 32'd0);
    chk("d3_out", 32'(d3_out), 32'h808080);

`ifdef DDS_SWEEP_EN
    // linear sweep from zero
    wr(0, 3'd3, 32'd0);
    wr(0, 3'd0, 32'd0);
    wr(0, 3'd2, 32'd0);
    wr(0, 3'd4, 32'h0100_0000);
    do_set;
    @(negedge clk);
    wr(0, 3'd3, 32'd1);
    do_set;
    @(negedge clk);
    chk("sw0", 32'(out[7:0]), 32'h00);
    @(negedge clk);
    chk("sw1", 32'(out[7:0]), 32'h00);
    @(negedge clk);
    chk("sw2", 32'(out[7:0]), 32'h01);
    @(negedge clk);
    chk("sw3", 32'(out[7:0]), 32'h03);
    @(negedge clk);
    chk("sw4", 32'(out[7:0]), 32'h06);
`endif

    // reset during a commit cycle
    wr(0, 3'd2, 32'd1);
    do_set;
    chk("mr_rdy_pre", 32'(wr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_out", 32'(out), 32'h8080);
    chk("mr_rdy", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 3'd3, 32'd1);
    @(negedge clk);
    chk("mr_silent", 32'(out), 32'h8080);
    do_set;
    @(negedge clk);
    chk("mr_new", 32'(out), 32'h8000);
    @(negedge clk);
    chk("mr_new2", 32'(out), 32'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
